univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 22 ++
 rtl/usr_burst_ctrl.sv | 90 +++++++++
 rtl/univ_shift_reg.sv | 109 ++++++++++
 tb/tb_univ_shift_reg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register.
// Mode select values and burst controller FSM states.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    function automatic logic is_shift(input logic [1:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: FSM, down-counter, latched mode, busy/done.
// UNIV_SHIFT_REG_ROTATE_EN adds a latched rotate flag.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] count,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic          rot,
    output logic          lrot,
`endif
    output logic          idle,
    output logic          shift_go,
    output logic [1:0]    lmode,
    output logic          busy,
    output logic          done
);

    state_e        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    lmode_d;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic          lrot_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            lmode <= MODE_HOLD;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            lrot  <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            lmode <= lmode_d;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            lrot  <= lrot_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        lmode_d = lmode;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        lrot_d  = lrot;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    lmode_d = mode;
                    cnt_d   = count;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                    lrot_d  = rot;
`endif
                    // Non-shift modes or empty bursts complete immediately
                    if (is_shift(mode) && (count != '0))
                        state_d = SHIFT;
                    else
                        state_d = DONE;
                end
            end
            SHIFT: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign idle     = (state == IDLE);
    assign shift_go = (state == SHIFT);
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and burst shifting.
// Define UNIV_SHIFT_REG_ROTATE_EN to add the rot (wrap) input.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CW-1:0]    count,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic             idle;
    logic             shift_go;
    logic [1:0]       lmode;
    logic [1:0]       op;
    logic             in_r, in_l;
    logic [WIDTH-1:0] q_d;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic             lrot;
    logic             rot_sel;
`endif

    usr_burst_ctrl #(
        .CW(CW)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .count    (count),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot      (rot),
        .lrot     (lrot),
`endif
        .idle     (idle),
        .shift_go (shift_go),
        .lmode    (lmode),
        .busy     (busy),
        .done     (done)
    );

    // Burst uses latched controls; start in IDLE suppresses single-step
    always_comb begin
        op = MODE_HOLD;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        rot_sel = 1'b0;
`endif
        if (shift_go) begin
            op = lmode;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            rot_sel = lrot;
`endif
        end else if (idle && !start && en) begin
            op = mode;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            rot_sel = rot;
`endif
        end
    end

    always_comb begin
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        in_r = rot_sel ? q[0] : sin_r;
        in_l = rot_sel ? q[WIDTH-1] : sin_l;
`else
        in_r = sin_r;
        in_l = sin_l;
`endif
    end

    always_comb begin
        q_d = q;
        unique case (op)
            MODE_SHR:  q_d = {in_r, q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q[WIDTH-2:0], in_l};
            MODE_LOAD: q_d = d;
            default:   q_d = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else
            q <= q_d;
    end

    assign qbar   = ~q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed test of univ_shift_reg at WIDTH=4.
// Hand-computed expectations for single-step, burst and reset cases.
module tb_univ_shift_reg;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          en = 1'b0;
    logic [W-1:0]  d = 4'b1111;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic          rot = 1'b0;
`endif
    logic [W-1:0]  q, qbar;
    logic          sout_r, sout_l, busy, done;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .en     (en),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .start  (start),
        .count  (count),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .qbar   (qbar),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_q", q, 4'b0000);
        check("rst_qbar", qbar, 4'b1111);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        mode = 2'b11; en = 1'b1; d = 4'b1010;
        step();
        check("load_q", q, 4'b1010);
        check("load_qbar", qbar, 4'b0101);
        check("sout_l", sout_l, 1'b1);
        check("sout_r", sout_r, 1'b0);

        mode = 2'b01; sin_r = 1'b1;
        step();
        check("shr_q", q, 4'b1101);
        mode = 2'b10; sin_l = 1'b0;
        step();
        check("shl_q", q, 4'b1010);
        en = 1'b0;
        step();
        check("hold_q", q, 4'b1010);

        // Burst left by 3 from 1100
        mode = 2'b11; en = 1'b1; d = 4'b1100;
        step();
        check("load2_q", q, 4'b1100);
        start = 1'b1; mode = 2'b10; count = 3; sin_l = 1'b0;
        step();
        check("bs_start_q", q, 4'b1100);
        check("bs_start_busy", busy, 1'b1);
        start = 1'b0; mode = 2'b11; d = 4'b0111;
        step();
        check("bs1_q", q, 4'b1000);
        check("bs1_busy", busy, 1'b1);
        step();
        check("bs2_q", q, 4'b0000);
        check("bs2_busy", busy, 1'b1);
        step();
        check("bs3_q", q, 4'b0000);
        check("bs3_done", done, 1'b1);
        check("bs3_busy", busy, 1'b0);
        en = 1'b0;
        step();
        check("bs_after_done", done, 1'b0);

        // Degenerate bursts
        mode = 2'b11; en = 1'b1; d = 4'b0110;
        step();
        en = 1'b0;
        start = 1'b1; mode = 2'b01; count = 0;
        step();
        start = 1'b0;
        check("c0_done", done, 1'b1);
        check("c0_busy", busy, 1'b0);
        check("c0_q", q, 4'b0110);
        step();
        check("c0_done_end", done, 1'b0);
        start = 1'b1; mode = 2'b11; count = 2; d = 4'b1111;
        step();
        start = 1'b0;
        check("ld_done", done, 1'b1);
        check("ld_busy", busy, 1'b0);
        check("ld_q", q, 4'b0110);
        step();

        // Count above WIDTH, live serial input
        start = 1'b1; mode = 2'b01; count = 6; sin_r = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("c6_busy", busy, 1'b1);
        check("c6_q5", q, 4'b1111);
        sin_r = 1'b0;
        step();
        check("c6_q", q, 4'b0111);
        check("c6_done", done, 1'b1);
        step();

        // Reset mid-burst
        mode = 2'b11; en = 1'b1; d = 4'b0000;
        step();
        en = 1'b0;
        start = 1'b1; mode = 2'b01; count = 4; sin_r = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("ab_q2", q, 4'b1100);
        rst = 1'b0;
        #1;
        check("ab_q", q, 4'b0000);
        check("ab_qbar", qbar, 4'b1111);
        check("ab_busy", busy, 1'b0);
        #2;
        rst = 1'b1;
        step();
        check("ab_done", done, 1'b0);
        check("ab_busy2", busy, 1'b0);
        check("ab_q3", q, 4'b0000);
        mode = 2'b11; en = 1'b1; d = 4'b0101;
        step();
        check("resume_q", q, 4'b0101);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
